muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to begin an operation; sampled only when idle.
REQ-004 SHALL have port op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port a, input, 32, operand A (GPR rs read data; multiplicand / dividend).
REQ-006 SHALL have port b, input, 32, operand B (GPR rt read data; multiplier / divisor).
REQ-007 SHALL have port we_hi, input, 1, MTHI write enable.
REQ-008 SHALL have port we_lo, input, 1, MTLO write enable.
REQ-009 SHALL have port wdata, input, 32, MTHI/MTLO write data.
REQ-010 SHALL have port busy, output, 1, high while an operation is in flight; the pipeline stalls MFHI/MFLO/new mul-div on it.
REQ-011 SHALL have port done, output, 1, one-cycle pulse: hi/lo just updated by a completed operation.
REQ-012 SHALL have port hi, output, 32, HI register (product high word / remainder).
REQ-013 SHALL have port lo, output, 32, LO register (product low word / quotient).

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN, FIX; busy = (state != IDLE), registered.
REQ-015 SHALL, in IDLE with start=1 at edge k, latch op and absolute-value operands (signed ops) or raw operands (unsigned ops), clear the iteration counter, and enter RUN.
REQ-016 SHALL perform one radix-2 step per cycle in RUN (shift-add multiply or restoring divide); 32 cycles, then FIX.
REQ-017 SHALL, in FIX, apply sign correction, write hi/lo on the FIX->IDLE edge (edge k+33), and assert done for exactly the following cycle.
REQ-018 SHALL keep hi/lo unchanged from edge k through edge k+32; no partial results visible.
REQ-019 SHALL produce for MULT the signed 64-bit product {hi,lo} = a*b; for MULTU the unsigned product.
REQ-020 SHALL produce for DIV a quotient truncated toward zero in lo and a remainder in hi with the sign of the dividend; for DIVU the unsigned quotient/remainder.
REQ-021 SHALL, on divisor zero, still take 33 cycles and yield lo=32'hFFFFFFFF, hi=a (raw operand), for both DIV and DIVU.
REQ-022 SHALL, for DIV a=32'h80000000, b=32'hFFFFFFFF, yield lo=32'h80000000, hi=0.
REQ-023 SHALL ignore start, we_hi, and we_lo while busy=1; no queuing.
REQ-024 SHALL, in IDLE, write wdata to hi on we_hi and to lo on we_lo at the edge; both may write in the same cycle.
REQ-025 SHALL, on start together with we_hi/we_lo in IDLE, accept start and drop the writes.
REQ-026 SHALL never assert done except the single cycle after FIX; back-to-back start in the done cycle is accepted (IDLE).

Reset
REQ-027 SHALL, on rst=1 at any edge, including mid-RUN or FIX, force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0; the in-flight operation is discarded.
REQ-028 SHALL give rst priority over start and we_hi/we_lo in the same cycle.

Verification
REQ-029 SHALL cover MULT a=32'hFFFFFFFE (-2), b=3 -> after 33 cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done for 1 cycle, busy high exactly 33 cycles.
REQ-030 SHALL cover MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-031 SHALL cover DIV a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-032 SHALL cover start pulses and we_lo=1 wdata=5 asserted during RUN -> ignored; result and lo equal the first operation's values.
REQ-033 SHALL cover rst at cycle 10 of RUN -> next cycle busy=0, hi=lo=0, no done pulse; a fresh start then completes normally.
REQ-034 SHALL cover IDLE we_hi=1 we_lo=1 wdata=32'h1234 -> hi=lo=32'h1234 next cycle, done stays 0; same with start=1 -> writes dropped, operation runs.

Source files
------------

// File: rtl/muldiv.sv
// Iterative 32x32 multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle; results appear on hi/lo only when the operation completes.
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic        isDiv;
  logic        negA;
  logic        negB;
  logic [31:0] rawA;
  logic [31:0] magB;
  logic [63:0] acc;

  logic        opSigned;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [32:0] divShift;
  logic        divFits;
  logic [31:0] divRem;
  logic [63:0] divNext;
  logic [31:0] fixHi;
  logic [31:0] fixLo;

  // Operand conditioning: signed ops work on magnitudes, sign restored in FIX.
  always_comb begin
    opSigned = ~op[0];
    absA     = (opSigned && a[31]) ? (~a + 32'd1) : a;
    absB     = (opSigned && b[31]) ? (~b + 32'd1) : b;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mulSum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, magB} : 33'd0);
    mulNext  = {mulSum, acc[31:1]};
    divShift = {acc[63:32], acc[31]};
    divFits  = (divShift >= {1'b0, magB});
    divRem   = divFits ? 32'(divShift - {1'b0, magB}) : divShift[31:0];
    divNext  = {divRem, acc[30:0], divFits};
  end

  // Sign correction; a zero divisor bypasses it and returns the raw dividend.
  always_comb begin
    fixHi = acc[63:32];
    fixLo = acc[31:0];
    if (isDiv) begin
      if (magB == 32'd0) begin
        fixHi = rawA;
        fixLo = 32'hFFFF_FFFF;
      end else begin
        fixHi = negA ? (~acc[63:32] + 32'd1) : acc[63:32];
        fixLo = (negA ^ negB) ? (~acc[31:0] + 32'd1) : acc[31:0];
      end
    end else if (negA ^ negB) begin
      {fixHi, fixLo} = ~acc + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      count <= 5'd0;
      isDiv <= 1'b0;
      negA  <= 1'b0;
      negB  <= 1'b0;
      rawA  <= 32'd0;
      magB  <= 32'd0;
      acc   <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            count <= 5'd0;
            isDiv <= op[1];
            negA  <= opSigned & a[31];
            negB  <= opSigned & b[31];
            rawA  <= a;
            magB  <= absB;
            acc   <= {32'd0, absA};
          end else begin
            if (we_hi) hi <= wdata;
            if (we_lo) lo <= wdata;
          end
        end
        RUN: begin
          acc   <= isDiv ? divNext : mulNext;
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
        end
        FIX: begin
          hi    <= fixHi;
          lo    <= fixLo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: cycle-level reference model plus directed vectors
// with hand-computed results.
module tb_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 0;

  int          remain;
  logic [31:0] modelHi;
  logic [31:0] modelLo;
  logic        modelDone;
  logic [63:0] pending;

  muldiv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic wh, input logic wl,
                               input logic [31:0] wd);
    start = s;
    op    = o;
    a     = x;
    b     = y;
    we_hi = wh;
    we_lo = wl;
    wdata = wd;
  endtask

  // Architectural result {hi,lo} of one operation, straight from the arithmetic rules.
  function automatic logic [63:0] expectedResult(input logic [1:0] o, input logic [31:0] x,
                                                 input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = $signed(x);
    sy = $signed(y);
    res = 64'd0;
    case (o)
      2'b00: res = sx * sy;
      2'b01: res = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Timing model: an accepted start keeps the unit busy 33 cycles, then results land with done.
  always @(posedge clk) begin
    if (rst) begin
      remain    = 0;
      modelHi   = 32'd0;
      modelLo   = 32'd0;
      modelDone = 1'b0;
    end else begin
      modelDone = 1'b0;
      if (remain == 0) begin
        if (start) begin
          remain  = 33;
          pending = expectedResult(op, a, b);
        end else begin
          if (we_hi) modelHi = wdata;
          if (we_lo) modelLo = wdata;
        end
      end else begin
        remain--;
        if (remain == 0) begin
          {modelHi, modelLo} = pending;
          modelDone = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 32'(busy), 32'(remain != 0));
      checkOutput("done", 32'(done), 32'(modelDone));
      checkOutput("hi", hi, modelHi);
      checkOutput("lo", lo, modelLo);
    end
  end

  task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit noWait, input bit disturb, input bit withWrites,
                       output int busyCycles, output int doneCycles);
    if (!noWait) @(negedge clk);
    applyStimulus(1'b1, o, x, y, withWrites, withWrites, 32'hBEEF);
    busyCycles = 0;
    doneCycles = 0;
    for (int i = 0; i < 60 && doneCycles == 0; i++) begin
      @(negedge clk);
      if (disturb && i >= 3 && i <= 8)
        applyStimulus(1'b1, 2'b11, 32'd1, 32'd1, 1'b1, 1'b1, 32'd5);
      else
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      if (busy) busyCycles++;
      if (done) doneCycles++;
    end
    if (doneCycles == 0) checkOutput("opTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    int busyCycles, doneCycles, doneSeen;
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkEn = 1;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetHi", hi, 32'd0);
    checkOutput("resetLo", lo, 32'd0);

    runOp(2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, busyCycles, doneCycles);
    checkOutput("multHi", hi, 32'hFFFF_FFFF);
    checkOutput("multLo", lo, 32'hFFFF_FFFA);
    checkOutput("multBusyCycles", 32'(busyCycles), 32'd33);
    @(negedge clk);
    checkOutput("doneWidth", 32'(done), 32'd0);

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, busyCycles, doneCycles);
    checkOutput("multuHi", hi, 32'hFFFF_FFFE);
    checkOutput("multuLo", lo, 32'h0000_0001);

    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, busyCycles, doneCycles);
    checkOutput("divLo", lo, 32'hFFFF_FFFD);
    checkOutput("divHi", hi, 32'hFFFF_FFFF);

    runOp(2'b11, 32'd7, 32'd0, 0, 0, 0, busyCycles, doneCycles);
    checkOutput("divuZeroLo", lo, 32'hFFFF_FFFF);
    checkOutput("divuZeroHi", hi, 32'd7);
    checkOutput("divuZeroBusy", 32'(busyCycles), 32'd33);

    runOp(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0, 0, busyCycles, doneCycles);
    checkOutput("divZeroLo", lo, 32'hFFFF_FFFF);
    checkOutput("divZeroHi", hi, 32'hFFFF_FFF9);

    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, busyCycles, doneCycles);
    checkOutput("divOvfLo", lo, 32'h8000_0000);
    checkOutput("divOvfHi", hi, 32'd0);

    runOp(2'b10, 32'd100, 32'hFFFF_FFF9, 0, 0, 0, busyCycles, doneCycles);
    checkOutput("divNegLo", lo, 32'hFFFF_FFF2);
    checkOutput("divNegHi", hi, 32'd2);

    // Back-to-back: new start issued in the done cycle.
    runOp(2'b01, 32'd6, 32'd7, 1, 0, 0, busyCycles, doneCycles);
    checkOutput("b2bLo", lo, 32'd42);
    checkOutput("b2bBusy", 32'(busyCycles), 32'd33);

    runOp(2'b01, 32'd1000, 32'd1000, 0, 1, 0, busyCycles, doneCycles);
    checkOutput("ignoreLo", lo, 32'd1000000);
    checkOutput("ignoreHi", hi, 32'd0);

    // Reset ten cycles into RUN discards the operation.
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 32'd5, 32'd6, 1'b0, 1'b0, 32'd0);
    repeat (11) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstRunBusy", 32'(busy), 32'd0);
    checkOutput("rstRunHi", hi, 32'd0);
    checkOutput("rstRunLo", lo, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("rstNoDone", 32'(doneSeen), 32'd0);
    runOp(2'b00, 32'd5, 32'd6, 0, 0, 0, busyCycles, doneCycles);
    checkOutput("afterRstLo", lo, 32'd30);

    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'h1234);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("mtHi", hi, 32'h1234);
    checkOutput("mtLo", lo, 32'h1234);
    checkOutput("mtDone", 32'(done), 32'd0);

    runOp(2'b01, 32'd2, 32'd3, 0, 0, 1, busyCycles, doneCycles);
    checkOutput("startWinsLo", lo, 32'd6);
    checkOutput("startWinsHi", hi, 32'd0);

    // Reset beats simultaneous start and writes.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 2'b00, 32'd3, 32'd3, 1'b1, 1'b1, 32'hAAAA);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("rstPrioBusy", 32'(busy), 32'd0);
    checkOutput("rstPrioHi", hi, 32'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
